// File: rtl/spi_ss_master_if.sv
// Handshake and serial bus bundle for spi_ss_master.
interface spi_ss_master_if #(
    parameter int unsigned DATA_W = 8
);
    logic              start;
    logic [3:0]        slave_id;
    logic [DATA_W-1:0] tx_data;
    logic              miso;
    logic              sclk;
    logic              mosi;
    logic [3:0]        sel_addr;
    logic              sel_en;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;

    modport master (
        input  start, slave_id, tx_data, miso,
        output sclk, mosi, sel_addr, sel_en, busy, done, rx_data
    );

    modport slave (
        output start, slave_id, tx_data, miso,
        input  sclk, mosi, sel_addr, sel_en, busy, done, rx_data
    );
endinterface

// File: rtl/spi_ss_master.sv
// SPI mode-0 master driving an external 1-to-16 slave-select decoder.
// Optional macro SPI_LOOPBACK_EN routes the outgoing bit back into the receiver.
module spi_ss_master #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    spi_ss_master_if.master         bus
);

    localparam int unsigned DIV_W  = 8;
    localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGES    = EDGE_W'(2 * DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [EDGE_W-1:0]  edge_q, edge_d;
    logic               sclk_q, sclk_d;
    logic [DATA_W-1:0]  tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0]  rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic [3:0]         sel_addr_q, sel_addr_d;
    logic               sel_en_q, sel_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sample_bit;

    // The MSB of the transmit shifter is the mosi line itself.
`ifdef SPI_LOOPBACK_EN
    wire unused_miso = bus.miso;
    assign sample_bit = tx_sh_q[DATA_W-1];
`else
    assign sample_bit = bus.miso;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            edge_q     <= '0;
            sclk_q     <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            sel_addr_q <= '0;
            sel_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            sclk_q     <= sclk_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            sel_addr_q <= sel_addr_d;
            sel_en_q   <= sel_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        edge_d     = edge_q;
        sclk_d     = sclk_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        sel_addr_d = sel_addr_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                sclk_d  = 1'b0;
                tx_sh_d = '0;
                if (bus.start) begin
                    state_d    = S_SETUP;
                    div_d      = '0;
                    edge_d     = '0;
                    rx_sh_d    = '0;
                    tx_sh_d    = bus.tx_data;
                    // Decoder reads sel_addr[0] as its MSB, so the id goes in bit-reversed.
                    sel_addr_d = {bus.slave_id[0], bus.slave_id[1],
                                  bus.slave_id[2], bus.slave_id[3]};
                end
            end
            S_SETUP: begin
                if (div_q == DIV_LAST) begin
                    state_d = S_SHIFT;
                    div_d   = '0;
                end else begin
                    div_d = DIV_W'(div_q + 1'b1);
                end
            end
            S_SHIFT: begin
                // One settling cycle at sclk=0 follows the final falling edge.
                if (edge_q == EDGES) begin
                    state_d = S_HOLD;
                    div_d   = '0;
                end else if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    edge_d = EDGE_W'(edge_q + 1'b1);
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_sh_d = {rx_sh_q[DATA_W-2:0], sample_bit};
                    end else if (edge_q != EDGE_W'(EDGES - 1'b1)) begin
                        tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    div_d = DIV_W'(div_q + 1'b1);
                end
            end
            S_HOLD: begin
                if (div_q == DIV_LAST) begin
                    state_d   = S_DONE;
                    div_d     = '0;
                    done_d    = 1'b1;
                    rx_data_d = rx_sh_q;
                    tx_sh_d   = '0;
                end else begin
                    div_d = DIV_W'(div_q + 1'b1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        sel_en_d = (state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD);
        busy_d   = sel_en_d;
    end

    assign bus.sclk     = sclk_q;
    assign bus.mosi     = tx_sh_q[DATA_W-1];
    assign bus.sel_addr = sel_addr_q;
    assign bus.sel_en   = sel_en_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_ss_master.sv
// Self-checking bench for spi_ss_master: timeline model, slave model and directed scenarios.
module tb_spi_ss_master;

    localparam int DW     = 8;
    localparam int CD     = 4;
    localparam int IW     = $clog2(DW);
    localparam int T_DONE = (2 * DW + 2) * CD + 1;
    localparam int T_SEL  = (2 * DW + 2) * CD;
`ifdef SPI_LOOPBACK_EN
    localparam logic [DW-1:0] EXP_A  = 8'hA5;
    localparam logic [DW-1:0] EXP_LB = 8'h5A;
    localparam bit            LOOPBK = 1'b1;
`else
    localparam logic [DW-1:0] EXP_A  = 8'h3C;
    localparam logic [DW-1:0] EXP_LB = 8'hFF;
    localparam bit            LOOPBK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_ss_master_if #(.DATA_W(DW)) bus();
    spi_ss_master #(.DATA_W(DW), .CLK_DIV(CD)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave: presents its word MSB first, next bit after each sclk rise.
    logic [DW-1:0] slave_word = '0;
    logic [DW-1:0] mosi_cap = '0;
    int            rise_cnt = 0;
    logic          miso_c;

    always @(posedge bus.sclk or negedge bus.sel_en) begin
        if (!bus.sel_en) begin
            rise_cnt <= 0;
        end else begin
            rise_cnt <= rise_cnt + 1;
            mosi_cap <= {mosi_cap[DW-2:0], bus.mosi};
        end
    end

    always_comb miso_c = (rise_cnt < DW) ? slave_word[IW'(DW - 1 - rise_cnt)] : 1'b0;
    assign bus.miso = miso_c;

    // Timeline model: t counts cycles since the accepting edge.
    bit            m_active = 1'b0;
    int            m_t = 0;
    logic [3:0]    m_id = '0;
    logic [DW-1:0] m_tx = '0;
    logic [DW-1:0] m_word = '0;
    logic [DW-1:0] m_rx = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_id     <= '0;
            m_rx     <= '0;
        end else if (!m_active) begin
            if (bus.start) begin
                m_active <= 1'b1;
                m_t      <= 0;
                m_id     <= bus.slave_id;
                m_tx     <= bus.tx_data;
                m_word   <= slave_word;
            end
        end else begin
            m_t <= m_t + 1;
            if (m_t + 1 == T_DONE) m_rx <= LOOPBK ? m_tx : m_word;
            if (m_t == T_DONE) m_active <= 1'b0;
        end
    end

    always @(negedge clk) begin : cmp
        int            edges;
        logic          e_sel, e_done, e_sclk, e_mosi;
        logic [3:0]    e_addr;
        if (bus.done) done_cnt++;
        if (chk_en) begin
            e_sel  = m_active && (m_t <= T_SEL);
            e_done = m_active && (m_t == T_DONE);
            edges  = (m_t >= CD) ? (m_t - CD) / CD : 0;
            if (edges > 2 * DW) edges = 2 * DW;
            e_sclk = e_sel && (m_t >= CD) && (edges % 2 == 1);
            e_mosi = e_sel && m_tx[IW'(DW - 1 - ((edges / 2 > DW - 1) ? DW - 1 : edges / 2))];
            for (int b = 0; b < 4; b++) e_addr[b] = m_id[3 - b];
            check("sclk",     32'(bus.sclk),     32'(e_sclk));
            check("mosi",     32'(bus.mosi),     32'(e_mosi));
            check("sel_en",   32'(bus.sel_en),   32'(e_sel));
            check("busy",     32'(bus.busy),     32'(e_sel));
            check("done",     32'(bus.done),     32'(e_done));
            check("sel_addr", 32'(bus.sel_addr), 32'(e_addr));
            check("rx_data",  32'(bus.rx_data),  32'(m_rx));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_xfer(input logic [3:0] id, input logic [DW-1:0] tx, input logic [DW-1:0] word);
        slave_word   = word;
        bus.slave_id = id;
        bus.tx_data  = tx;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int lat);
        lat = -1;
        for (int n = n0 + 1; n <= n0 + 400; n++) begin
            tick();
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        int dc;
        int pulses;
        logic [3:0] ids [3];
        logic [3:0] adr [3];
        bus.start    = 1'b0;
        bus.slave_id = '0;
        bus.tx_data  = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_sel_en", 32'(bus.sel_en), 32'd0);
        check("rst_rx",     32'(bus.rx_data), 32'd0);
        rst = 1'b0;
        tick();

        // Reference transfer: slave 5, 0xA5 out, 0x3C in.
        start_xfer(4'd5, 8'hA5, 8'h3C);
        repeat (10) tick();
        check("a_sel_addr", 32'(bus.sel_addr), 32'b1010);
        check("a_sel_en",   32'(bus.sel_en),   32'd1);
        wait_done(10, lat);
        check("a_latency", 32'(lat), 32'd73);
        check("a_rx",      32'(bus.rx_data), 32'(EXP_A));
        check("a_mosi",    32'(mosi_cap),    32'hA5);
        tick();

        // start while busy must be ignored.
        start_xfer(4'd1, 8'h33, 8'hC3);
        dc = done_cnt;
        repeat (20) tick();
        bus.slave_id = 4'd9;
        bus.tx_data  = 8'hFF;
        bus.start    = 1'b1;
        repeat (10) tick();
        bus.start    = 1'b0;
        check("b_sel_addr", 32'(bus.sel_addr), 32'b1000);
        wait_done(30, lat);
        check("b_latency", 32'(lat), 32'd73);
        check("b_rx", 32'(bus.rx_data), LOOPBK ? 32'h33 : 32'hC3);
        repeat (3) tick();
        check("b_done_cnt", 32'(done_cnt - dc), 32'd1);

        // Reset at the 5th sclk edge, then a clean transfer.
        start_xfer(4'd7, 8'h96, 8'h69);
        repeat (23) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("r_sclk",   32'(bus.sclk),   32'd0);
        check("r_sel_en", 32'(bus.sel_en), 32'd0);
        check("r_busy",   32'(bus.busy),   32'd0);
        check("r_done",   32'(bus.done),   32'd0);
        dc = done_cnt;
        repeat (100) tick();
        check("r_no_done", 32'(done_cnt - dc), 32'd0);
        start_xfer(4'd3, 8'h5C, 8'hE1);
        wait_done(0, lat);
        check("r_latency",  32'(lat), 32'd73);
        check("r_sel_addr", 32'(bus.sel_addr), 32'b1100);
        check("r_rx", 32'(bus.rx_data), LOOPBK ? 32'h5C : 32'hE1);
        tick();

        // start held high: back-to-back transfers with one idle cycle between.
        slave_word   = 8'h81;
        bus.slave_id = 4'd2;
        bus.tx_data  = 8'h7E;
        bus.start    = 1'b1;
        pulses = 0;
        for (int n = 0; n < 400 && pulses < 3; n++) begin
            tick();
            if (bus.done) begin
                pulses++;
                if (pulses == 3) bus.start = 1'b0;
                tick();
                check("c_idle_sel_en", 32'(bus.sel_en), 32'd0);
                tick();
                check("c_next_sel_en", 32'(bus.sel_en), (pulses < 3) ? 32'd1 : 32'd0);
            end
        end
        check("c_pulses", 32'(pulses), 32'd3);
        tick();

        // Address bit reversal corners.
        ids = '{4'd0, 4'd1, 4'd15};
        adr = '{4'b0000, 4'b1000, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            start_xfer(ids[i], 8'h3C, 8'hA5);
            repeat (2) tick();
            check("d_sel_addr", 32'(bus.sel_addr), 32'(adr[i]));
            wait_done(2, lat);
            tick();
        end

        // miso stuck high: loopback returns tx, otherwise all ones.
        start_xfer(4'd6, 8'h5A, 8'hFF);
        wait_done(0, lat);
        check("e_rx", 32'(bus.rx_data), 32'(EXP_LB));
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_ss_master.md
SPI_SS_MASTER -- requirements
Module: spi_ss_master

Interface
REQ-001 SHALL have parameter DATA_W, default 8: transfer length in bits; legal range 2..32.
REQ-002 SHALL have parameter CLK_DIV, default 4: sclk half-period in clk cycles; legal range 1..255.
REQ-003 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, synchronous and active-high.
REQ-005 SHALL have port start  input  1  transfer request; sampled only in IDLE.
REQ-006 SHALL have port slave_id  input  4  target slave number 0..15; latched with start.
REQ-007 SHALL have port tx_data  input  DATA_W  data to send, MSB first; latched with start.
REQ-008 SHALL have port miso  input  1  serial data from the selected slave.
REQ-009 SHALL have port sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-010 SHALL have port mosi  output  1  serial data to the slave.
REQ-011 SHALL have port sel_addr  output  4  select address for the downstream 1-to-16 select decoder.
REQ-012 SHALL have port sel_en  output  1  select enable; drives the decoder data input, so high means one slave is selected.
REQ-013 SHALL have port busy  output  1  high from the cycle after start is accepted through HOLD.
REQ-014 SHALL have port done  output  1  one-cycle pulse at transfer end.
REQ-015 SHALL have port rx_data  output  DATA_W  received word; held until the next done.

Function
REQ-016 SHALL implement the FSM IDLE->SETUP->SHIFT->HOLD->DONE->IDLE, one step per transition condition below.
REQ-017 IDLE with start=1 SHALL latch slave_id and tx_data and move to SETUP on the next edge; start in any other state SHALL be ignored.
REQ-018 SHALL drive sel_addr as {slave_id[0],slave_id[1],slave_id[2],slave_id[3]}, because the decoder treats sel_addr[0] as MSB; decoder output index then equals slave_id.
REQ-019 SHALL keep sel_addr constant from SETUP through DONE; it changes only on start acceptance.
REQ-020 SHALL hold sel_en=1 in SETUP, SHIFT and HOLD, and 0 in IDLE and DONE.
REQ-021 SETUP SHALL last CLK_DIV cycles with sclk=0 and mosi=tx_data[DATA_W-1].
REQ-022 SHIFT SHALL toggle sclk every CLK_DIV cycles, for exactly 2*DATA_W edges, ending at sclk=0.
REQ-023 SHALL sample miso on each sclk rising edge, shifting it into the LSB.
REQ-024 SHALL advance mosi to the next bit on each falling edge except the last.
REQ-025 HOLD SHALL last CLK_DIV cycles with sclk=0; DONE SHALL last 1 cycle.
REQ-026 In DONE, SHALL pulse done=1 and update rx_data with the assembled word.
REQ-027 Latency SHALL be fixed: if start is sampled at edge k, done is high in the cycle after edge k+(2*DATA_W+2)*CLK_DIV+1 (73 for the defaults).
REQ-028 With start held high, transfers SHALL be separated by exactly one IDLE cycle.
REQ-029 mosi SHALL be 0 whenever sel_en=0.

Reset
REQ-030 rst=1 at any edge, including mid-transfer, SHALL force IDLE with sclk=0, mosi=0, sel_en=0, sel_addr=0, busy=0, done=0 and rx_data=0 on that edge.
REQ-031 rst SHALL override a simultaneous start; no transfer SHALL be pending after reset.

Configuration
REQ-032 Macro SPI_LOOPBACK_EN, when defined, SHALL make the sampling path take internal mosi instead of miso, with miso ignored and rx_data==tx_data after each transfer.
REQ-033 When SPI_LOOPBACK_EN is undefined, SHALL sample miso per REQ-023 with no loopback logic present.

Verification
REQ-034 Defaults; start with slave_id=5, tx_data=0xA5; slave model returns 0x3C -> sel_addr=4'b1010 and sel_en=1 for the whole transfer; mosi at rising edges is 1,0,1,0,0,1,0,1; done at edge k+73; rx_data=0x3C.
REQ-035 start with slave_id=9 asserted while busy -> ignored; sel_addr and the latched data are unchanged and the done count is unchanged.
REQ-036 rst asserted at the 5th sclk edge of SHIFT -> on the next cycle sclk=0, sel_en=0, busy=0 and no done; a following start with slave_id=3 completes normally.
REQ-037 start held high for 3 transfers -> 3 done pulses, each followed by exactly one idle cycle with sel_en=0.
REQ-038 slave_id values 0, 1 and 15 -> sel_addr 0000, 1000 and 1111 respectively.
REQ-039 SPI_LOOPBACK_EN defined, miso tied to 1, tx_data=0x5A -> rx_data=0x5A.
